// File: rtl/kf_axi_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : kf_axi_wr_arb
// Description : Burst-granular round-robin arbiter sharing one AXI4 write
//               master between the DDR4 result writer and the core output.
// Revision    : 1.0 - initial release
// ============================================================================
module kf_axi_wr_arb #(
    parameter int         NUM_REQ = 2,
    parameter int         ADDR_W  = 32,
    parameter int         DATA_W  = 512,
    parameter logic [2:0] AWSIZE  = 3'd6
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ*ADDR_W-1:0]       s_axi_awaddr,
    input  logic [NUM_REQ*8-1:0]            s_axi_awlen,
    input  logic [NUM_REQ-1:0]              s_axi_awvalid,
    output logic [NUM_REQ-1:0]              s_axi_awready,
    input  logic [NUM_REQ*DATA_W-1:0]       s_axi_wdata,
    input  logic [NUM_REQ*(DATA_W/8)-1:0]   s_axi_wstrb,
    input  logic [NUM_REQ-1:0]              s_axi_wvalid,
    output logic [NUM_REQ-1:0]              s_axi_wready,
    input  logic [NUM_REQ-1:0]              s_axi_wlast,
    output logic [NUM_REQ*2-1:0]            s_axi_bresp,
    output logic [NUM_REQ-1:0]              s_axi_bvalid,
    input  logic [NUM_REQ-1:0]              s_axi_bready,
    output logic [ADDR_W-1:0]               m_axi_awaddr,
    output logic [7:0]                      m_axi_awlen,
    output logic [2:0]                      m_axi_awsize,
    output logic [1:0]                      m_axi_awburst,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [DATA_W-1:0]               m_axi_wdata,
    output logic [DATA_W/8-1:0]             m_axi_wstrb,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    output logic                            m_axi_wlast,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    output logic                            grant_id,
    output logic                            len_err
);

    localparam int         c_STRB_W = DATA_W / 8;
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_AW     = 2'd1;
    localparam logic [1:0] c_W      = 2'd2;
    localparam logic [1:0] c_B      = 2'd3;

    logic [1:0]          r_state;
    logic                r_grant;
    logic                r_last_grant;
    logic [7:0]          r_beat_cnt;
    logic [7:0]          r_len_q;
    logic                r_len_err;

    logic                w_next_grant;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_b_hs;
    logic                w_sel_awvalid;
    logic                w_sel_wvalid;
    logic                w_sel_wlast;
    logic                w_sel_bready;
    logic [ADDR_W-1:0]   w_sel_awaddr;
    logic [7:0]          w_sel_awlen;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [c_STRB_W-1:0] w_sel_wstrb;

    // Slice selection follows the registered grant, never the live requests.
    always_comb begin
        w_sel_awvalid = s_axi_awvalid[r_grant];
        w_sel_wvalid  = s_axi_wvalid[r_grant];
        w_sel_wlast   = s_axi_wlast[r_grant];
        w_sel_bready  = s_axi_bready[r_grant];
        w_sel_awaddr  = r_grant ? s_axi_awaddr[2*ADDR_W-1:ADDR_W] : s_axi_awaddr[ADDR_W-1:0];
        w_sel_awlen   = r_grant ? s_axi_awlen[15:8] : s_axi_awlen[7:0];
        w_sel_wdata   = r_grant ? s_axi_wdata[2*DATA_W-1:DATA_W] : s_axi_wdata[DATA_W-1:0];
        w_sel_wstrb   = r_grant ? s_axi_wstrb[2*c_STRB_W-1:c_STRB_W] : s_axi_wstrb[c_STRB_W-1:0];
    end

    // Round-robin: the requester after last_grant has priority.
    assign w_next_grant = r_last_grant ? ~s_axi_awvalid[0] : s_axi_awvalid[1];

    assign m_axi_awaddr  = w_sel_awaddr;
    assign m_axi_awlen   = w_sel_awlen;
    assign m_axi_awsize  = AWSIZE;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = (r_state == c_AW) && w_sel_awvalid;
    assign m_axi_wdata   = w_sel_wdata;
    assign m_axi_wstrb   = w_sel_wstrb;
    assign m_axi_wvalid  = (r_state == c_W) && w_sel_wvalid;
    assign m_axi_wlast   = (r_state == c_W) && (r_beat_cnt == r_len_q);
    assign m_axi_bready  = (r_state == c_B) && w_sel_bready;
    assign grant_id      = r_grant;
    assign len_err       = r_len_err;

    assign w_aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_w_hs  = m_axi_wvalid && m_axi_wready;
    assign w_b_hs  = m_axi_bvalid && m_axi_bready;

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
            logic w_sel;
            assign w_sel                = (r_grant == 1'(i));
            assign s_axi_awready[i]     = w_sel && (r_state == c_AW) && m_axi_awready;
            assign s_axi_wready[i]      = w_sel && (r_state == c_W) && m_axi_wready;
            assign s_axi_bvalid[i]      = w_sel && (r_state == c_B) && m_axi_bvalid;
            assign s_axi_bresp[2*i +: 2] = (w_sel && (r_state == c_B)) ? m_axi_bresp : 2'b00;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_beat_cnt   <= 8'd0;
            r_len_q      <= 8'd0;
            r_len_err    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (|s_axi_awvalid) begin
                        r_grant <= w_next_grant;
                        r_state <= c_AW;
                    end
                end
                c_AW: begin
                    if (w_aw_hs) begin
                        r_len_q      <= w_sel_awlen;
                        r_beat_cnt   <= 8'd0;
                        r_last_grant <= r_grant;
                        r_state      <= c_W;
                    end
                end
                c_W: begin
                    if (w_w_hs) begin
                        // An 8-bit counter wraps naturally after beat 256.
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                        if (w_sel_wlast != m_axi_wlast) begin
                            r_len_err <= 1'b1;
                        end
                        if (m_axi_wlast) begin
                            r_state <= c_B;
                        end
                    end
                end
                c_B: begin
                    if (w_b_hs) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/kf_axi_wr_arb.md
Name: kf_axi_wr_arb

Overview:
Shares the single AXI4 write master (m2) between the two result writers: the final-result DDR4 writer and the per-iteration state/covariance output path in the Kalman core.
- Arbitration is burst-granular round-robin.
- The grant is held from the AW handshake until the matching B response, so only one transaction is outstanding.
- Sits between both writers and the top-level m2_axi_* ports.

Parameters:
NUM_REQ, 2, number of requesters (fixed at 2; index 0 = DDR4 writer, 1 = core output)
ADDR_W, 32, address width
DATA_W, 512, data width
AWSIZE, 3'd6, constant m_axi_awsize (64 B beats)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_axi_awaddr  in  NUM_REQ*ADDR_W  per-requester burst address, slice i = requester i
s_axi_awlen  in  NUM_REQ*8  per-requester burst length minus 1
s_axi_awvalid  in  NUM_REQ  AW request
s_axi_awready  out  NUM_REQ  AW accept, granted slice only
s_axi_wdata  in  NUM_REQ*DATA_W  write data
s_axi_wstrb  in  NUM_REQ*(DATA_W/8)  byte strobes
s_axi_wvalid  in  NUM_REQ  W valid
s_axi_wready  out  NUM_REQ  W ready, granted slice only
s_axi_wlast  in  NUM_REQ  requester's last-beat flag, checked only
s_axi_bresp  out  NUM_REQ*2  routed write response
s_axi_bvalid  out  NUM_REQ  routed B valid
s_axi_bready  in  NUM_REQ  B ready
m_axi_awaddr  out  ADDR_W  to m2
m_axi_awlen  out  8  to m2
m_axi_awsize  out  3  constant AWSIZE
m_axi_awburst  out  2  constant 2'b01 (INCR)
m_axi_awvalid  out  1  to m2
m_axi_awready  in  1  from m2
m_axi_wdata  out  DATA_W  to m2
m_axi_wstrb  out  DATA_W/8  to m2
m_axi_wvalid  out  1  to m2
m_axi_wready  in  1  from m2
m_axi_wlast  out  1  generated from internal beat counter
m_axi_bresp  in  2  from m2
m_axi_bvalid  in  1  from m2
m_axi_bready  out  1  to m2
grant_id  out  1  current or last owner
len_err  out  1  sticky wlast/awlen mismatch flag

Behaviour:
- Reset values:
  - state = IDLE, grant_id = 0, last_grant = 1, beat_cnt = 0, len_err = 0.
  - All valid and ready outputs are 0; awsize and awburst hold their constant values.
- FSM IDLE -> AW -> W -> B -> IDLE. Exactly one transaction is outstanding at a time.
- IDLE: if any s_axi_awvalid is set, grant the requester after last_grant in round-robin order. With both requesting and last_grant = 1, requester 0 wins. The grant registers, so the AW phase starts the following cycle. No requests: stay in IDLE.
- AW phase:
  - m_axi_awvalid, awaddr and awlen pass through combinationally from the granted slice.
  - s_axi_awready[g] = m_axi_awready.
  - On handshake: latch awlen into len_q, clear beat_cnt, update last_grant, go to W.
- W phase:
  - wdata, wstrb and wvalid pass through combinationally from the granted slice; s_axi_wready[g] = m_axi_wready.
  - m_axi_wlast = (beat_cnt == len_q).
  - Each beat handshake increments beat_cnt. The beat with m_axi_wlast set completes the phase and moves to B.
  - W beats are never forwarded before the AW handshake; s_axi_wready stays 0 outside the W phase.
  - len_err sets on any accepted beat where s_axi_wlast[g] != m_axi_wlast. It clears only on reset.
- B phase:
  - s_axi_bvalid[g] = m_axi_bvalid, s_axi_bresp[g] = m_axi_bresp, m_axi_bready = s_axi_bready[g].
  - On handshake, return to IDLE. Arbitration happens in the IDLE cycle, giving 1 idle cycle between bursts.
- Non-granted slices always see awready, wready and bvalid at 0, and bresp at 0.
- awlen = 0: a single beat, with wlast asserted on beat 0. awlen = 255: beat_cnt wraps only after the 256th beat, which exits the W phase.
- Asynchronous reset mid-burst: everything returns to reset values immediately, and the partial burst is abandoned.

Test Plan:
1. Requester 0 alone, awaddr 0x0050_0000, awlen 1 -> 1 AW, 2 W beats with m_axi_wlast on beat 1, B OKAY routed to s0 only; grant_id = 0.
2. Both AW valid in the same cycle after reset -> s0 served fully through B, then s1; the next simultaneous request goes to s0 again (alternation).
3. s1 mid-W with m_axi_wready toggling 1,0,1,0 -> beats are not lost or duplicated; s0 awready stays 0 throughout.
4. s0 awlen 3, asserts wlast on beat 2 -> len_err = 1, m_axi_wlast still on beat 3; len_err persists through later clean bursts.
5. bresp = 2'b10 (SLVERR) with bready held 0 for 5 cycles -> arbiter stays in B; SLVERR delivered to the owner only, and the next grant follows the handshake.
6. rst_n asserted during W beat 2 of 4 -> all valid/ready outputs are 0 immediately; after release, s0 gets the first grant.
